// File: rtl/acq_capture_ctrl.sv
// Trigger/capture sequencer: circular pre-trigger buffer, level/slope or auto trigger, post fill.
// Every capture leaves DEPTH ordered samples in RAM, oldest at start_addr, trigger at trig_addr.
module acq_capture_ctrl #(
  parameter int DEPTH = 102400,
  parameter int AW    = 17,
  parameter int DW    = 8,
  parameter int TW    = 24
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          arm,
  input  logic          abort,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_slope,
  input  logic          trig_auto,
  input  logic [TW-1:0] auto_timeout,
  input  logic [AW-1:0] pretrig_len,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_cs,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] trig_addr,
  output logic [AW-1:0] start_addr,
  output logic          auto_fired
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);

  state_t        state, state_nx;
  logic [AW-1:0] wptr;
  logic [AW-1:0] cnt;
  logic [AW-1:0] p_len;
  logic [DW-1:0] prev;
  logic          prev_vld;
  logic [TW-1:0] auto_cnt;

  logic          launch;
  logic          accept;
  logic          real_hit;
  logic          auto_hit;
  logic          fire;
  logic [AW-1:0] p_clamp;
  logic [AW-1:0] r_len;
  logic [AW-1:0] trig_src;
  logic [AW:0]   start_wide;
  logic [AW-1:0] start_calc;

  always_comb begin
    state_nx   = state;
    launch     = 1'b0;
    accept     = 1'b0;
    real_hit   = 1'b0;
    auto_hit   = 1'b0;
    fire       = 1'b0;
    p_clamp    = (pretrig_len > LAST) ? LAST : pretrig_len;
    r_len      = LAST - p_len;
    // Entering DONE straight from WAIT_TRIG uses the trigger address being written now.
    trig_src   = (state == S_WAIT) ? wptr : trig_addr;
    start_wide = {1'b0, trig_src} - {1'b0, p_len};
    if (trig_src < p_len) start_wide = start_wide + DEPTH_X;
    start_calc = start_wide[AW-1:0];

    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            launch   = 1'b1;
            state_nx = (p_clamp == '0) ? S_WAIT : S_PRE;
          end
        end
        S_PRE: begin
          if (sample_valid) begin
            accept = 1'b1;
            if (cnt == AW'(1)) state_nx = S_WAIT;
          end
        end
        S_WAIT: begin
          if (sample_valid) begin
            accept   = 1'b1;
            real_hit = prev_vld &&
                       (trig_slope ? (prev > trig_level && sample_data <= trig_level)
                                   : (prev < trig_level && sample_data >= trig_level));
            auto_hit = trig_auto &&
                       (auto_timeout == '0 ||
                        ({1'b0, auto_cnt} + (TW+1)'(1)) == {1'b0, auto_timeout});
            fire     = real_hit || auto_hit;
            if (fire) state_nx = (r_len == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (sample_valid) begin
            accept = 1'b1;
            if (cnt == AW'(1)) state_nx = S_DONE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_cs     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
      auto_fired <= 1'b0;
      wptr       <= '0;
      cnt        <= '0;
      p_len      <= '0;
      prev       <= '0;
      prev_vld   <= 1'b0;
      auto_cnt   <= '0;
    end else begin
      mem_we <= accept;
      busy   <= (state_nx == S_PRE) || (state_nx == S_WAIT) || (state_nx == S_POST);
      mem_cs <= (state_nx == S_PRE) || (state_nx == S_WAIT) || (state_nx == S_POST);
      done   <= (state_nx == S_DONE);

      if (launch) begin
        p_len      <= p_clamp;
        cnt        <= p_clamp;
        wptr       <= '0;
        auto_fired <= 1'b0;
        prev_vld   <= 1'b0;
        auto_cnt   <= '0;
      end

      if (accept) begin
        mem_addr  <= wptr;
        mem_wdata <= sample_data;
        wptr      <= (wptr == LAST) ? '0 : wptr + AW'(1);
        prev      <= sample_data;
        prev_vld  <= 1'b1;
        if (state == S_WAIT) begin
          auto_cnt <= auto_cnt + TW'(1);
          if (fire) cnt <= r_len;
        end else begin
          cnt <= cnt - AW'(1);
        end
      end

      if (fire) begin
        trig_addr  <= wptr;
        auto_fired <= !real_hit;
      end

      if (state_nx == S_DONE && state != S_DONE) start_addr <= start_calc;
    end
  end

endmodule

// File: tb/tb_acq_capture_ctrl.sv
// Directed bench for acq_capture_ctrl with a sample-count reference model checked every cycle.
module tb_acq_capture_ctrl;

  localparam int D  = 16;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic          trig_slope = 1'b0;
  logic          trig_auto = 1'b0;
  logic [TW-1:0] auto_timeout = '0;
  logic [AW-1:0] pretrig_len = '0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_cs;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;
  logic          auto_fired;

  acq_capture_ctrl #(.DEPTH(D), .AW(AW), .DW(DW), .TW(TW)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort),
    .trig_level(trig_level), .trig_slope(trig_slope), .trig_auto(trig_auto),
    .auto_timeout(auto_timeout), .pretrig_len(pretrig_len),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_cs(mem_cs),
    .busy(busy), .done(done), .trig_addr(trig_addr), .start_addr(start_addr),
    .auto_fired(auto_fired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a capture is a numbered run of accepted samples n = 0,1,2...
  // sample n lands at address n mod D; trigger index tn >= P; capture ends at n = tn + D - P - 1.
  int            m_n, m_p, m_tn;
  bit            m_active, m_trig, m_have_prev, m_real, m_auto;
  logic [DW-1:0] m_last;
  logic          e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_auto = 1'b0;
  logic [AW-1:0] e_addr = '0, e_trig = '0, e_start = '0;
  logic [DW-1:0] e_wdata = '0;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_active = 0; m_trig = 0; m_have_prev = 0; m_n = 0;
      e_we = 0; e_busy = 0; e_done = 0; e_auto = 0;
      e_addr = '0; e_trig = '0; e_start = '0; e_wdata = '0;
    end else begin
      e_we = 0;
      if (abort) begin
        m_active = 0;
        e_done   = 0;
      end else if (!m_active && arm) begin
        m_p = (int'(pretrig_len) > D - 1) ? D - 1 : int'(pretrig_len);
        m_active = 1; m_trig = 0; m_have_prev = 0; m_n = 0;
        e_done = 0; e_auto = 0;
      end else if (m_active && sample_valid) begin
        e_we    = 1;
        e_addr  = AW'(m_n % D);
        e_wdata = sample_data;
        if (!m_trig && m_n >= m_p) begin
          m_real = m_have_prev &&
                   (trig_slope ? (m_last > trig_level && sample_data <= trig_level)
                               : (m_last < trig_level && sample_data >= trig_level));
          m_auto = trig_auto && (int'(auto_timeout) == 0 || m_n - m_p + 1 == int'(auto_timeout));
          if (m_real || m_auto) begin
            m_trig = 1; m_tn = m_n;
            e_trig = AW'(m_n % D);
            e_auto = !m_real;
          end
        end
        if (m_trig && m_n == m_tn + D - m_p - 1) begin
          m_active = 0;
          e_done   = 1;
          e_start  = AW'(((m_tn % D) - m_p + D) % D);
        end
        m_last = sample_data; m_have_prev = 1; m_n++;
      end
      e_busy = m_active;
    end
  end

  initial forever begin
    @(negedge clk);
    if (mem_we === 1'b1) wr_cnt++;
    check("mem_we",     32'(mem_we),     32'(e_we));
    check("mem_cs",     32'(mem_cs),     32'(e_busy));
    check("busy",       32'(busy),       32'(e_busy));
    check("done",       32'(done),       32'(e_done));
    check("mem_addr",   32'(mem_addr),   32'(e_addr));
    check("mem_wdata",  32'(mem_wdata),  32'(e_wdata));
    check("trig_addr",  32'(trig_addr),  32'(e_trig));
    check("start_addr", 32'(start_addr), 32'(e_start));
    check("auto_fired", 32'(auto_fired), 32'(e_auto));
  end

  task automatic step(input logic a, input logic ab, input logic v, input logic [DW-1:0] d);
    arm = a; abort = ab; sample_valid = v; sample_data = d;
    @(negedge clk);
  endtask

  task automatic do_arm(input logic [AW-1:0] p, input logic [DW-1:0] lvl, input logic slope,
                        input logic au, input logic [TW-1:0] to);
    pretrig_len = p; trig_level = lvl; trig_slope = slope; trig_auto = au; auto_timeout = to;
    step(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic expect_result(input string tag, input int writes, input int ta, input int sa,
                               input logic af);
    check({tag, "_writes"}, 32'(wr_cnt), 32'(writes));
    check({tag, "_trig"},   32'(trig_addr), 32'(ta));
    check({tag, "_start"},  32'(start_addr), 32'(sa));
    check({tag, "_auto"},   32'(auto_fired), 32'(af));
    check({tag, "_done"},   32'(done), 32'd1);
    check({tag, "_busy"},   32'(busy), 32'd0);
  endtask

  logic [DW-1:0] t2 [6] = '{8'h50, 8'h30, 8'h50, 8'h50, 8'h60, 8'h40};
  logic [DW-1:0] t4 [4] = '{8'h90, 8'h90, 8'h10, 8'h90};

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we",   32'(mem_we), 32'd0);
    check("rst_trig", 32'(trig_addr), 32'd0);
    reset_n = 1'b1;
    step(0, 0, 1, 8'h11);

    // 1: rising ramp, P=4 -> trigger at sample 8 (0x80)
    wr_cnt = 0;
    do_arm(6'd4, 8'h80, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 24; k++) step(0, 0, 1, 8'(k * 16));
    step(0, 0, 0, 8'h00);
    expect_result("t1", 20, 8, 4, 1'b0);

    // 2: falling with gaps; the PRE-phase fall (0x50->0x30) must not trigger
    wr_cnt = 0;
    do_arm(6'd4, 8'h40, 1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 22; k++) begin
      step(0, 0, 1, (k < 6) ? t2[k] : 8'h20);
      step(0, 0, 0, 8'hFF);
    end
    expect_result("t2", 17, 5, 1, 1'b0);

    // 3: auto trigger on 5th WAIT_TRIG sample
    wr_cnt = 0;
    do_arm(6'd4, 8'h80, 1'b0, 1'b1, 8'd5);
    for (int k = 0; k < 24; k++) step(0, 0, 1, 8'h10);
    expect_result("t3", 20, 8, 4, 1'b1);

    // 4a: P=0, first sample cannot trigger even though it is above level
    wr_cnt = 0;
    do_arm(6'd0, 8'h80, 1'b0, 1'b0, 8'd0);
    check("t4a_busy_after_arm", 32'(busy), 32'd1);
    for (int k = 0; k < 22; k++) step(0, 0, 1, (k < 4) ? t4[k] : 8'h20);
    expect_result("t4a", 19, 3, 3, 1'b0);

    // 4b: pretrig_len=40 clamps to 15; done together with the trigger write
    wr_cnt = 0;
    do_arm(6'd40, 8'h80, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 16; k++) step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h90);
    check("t4b_done_now", 32'(done), 32'd1);
    check("t4b_we_now",   32'(mem_we), 32'd1);
    check("t4b_addr_now", 32'(mem_addr), 32'd0);
    step(0, 0, 1, 8'h90);
    expect_result("t4b", 17, 0, 1, 1'b0);

    // 5: abort mid-POST then re-arm
    do_arm(6'd4, 8'h80, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 12; k++) step(0, 0, 1, 8'(k * 16));
    step(1, 1, 1, 8'h55);
    check("t5_we",    32'(mem_we), 32'd0);
    check("t5_busy",  32'(busy), 32'd0);
    check("t5_done",  32'(done), 32'd0);
    check("t5_trig",  32'(trig_addr), 32'd8);
    check("t5_start", 32'(start_addr), 32'd1);
    step(0, 0, 1, 8'h66);
    do_arm(6'd4, 8'h80, 1'b0, 1'b0, 8'd0);
    step(0, 0, 1, 8'h77);
    check("t5_rearm_addr", 32'(mem_addr), 32'd0);
    check("t5_rearm_data", 32'(mem_wdata), 32'h77);

    // 6: arm while busy ignored, then async reset in WAIT_TRIG
    step(1, 0, 1, 8'h10);
    check("t6_ign_addr", 32'(mem_addr), 32'd1);
    check("t6_ign_busy", 32'(busy), 32'd1);
    step(1, 0, 0, 8'h00);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 8'h10);
    check("t6_pre_rst_we", 32'(mem_we), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_busy",  32'(busy), 32'd0);
    check("t6_rst_cs",    32'(mem_cs), 32'd0);
    check("t6_rst_we",    32'(mem_we), 32'd0);
    check("t6_rst_addr",  32'(mem_addr), 32'd0);
    check("t6_rst_trig",  32'(trig_addr), 32'd0);
    check("t6_rst_start", 32'(start_addr), 32'd1 - 32'd1);
    check("t6_rst_done",  32'(done), 32'd0);
    @(negedge clk);
    step(0, 0, 1, 8'h10);
    reset_n = 1'b1;
    step(0, 0, 1, 8'h10);
    step(0, 0, 0, 8'h00);
    check("t6_idle_we", 32'(mem_we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
